lcb_wake_sched: RTL and testbench
=================================

Name: lcb_wake_sched

Overview:
- Clock-enable scheduler for a bank of local clock buffers (LCBs), each driving a group of flops.
- Requesters (flop groups) ask for their LCB to run. The block sequences enables with a fixed wake-up latency and a hold-off (hysteresis) after the request drops.
- Limits di/dt by spacing LCB wake-ups at least WAKE_GAP cycles apart.
- Pending wake-ups are shared round-robin.
- Sits between the per-group activity logic and the LCB enable pins.

Parameters:
- NUM_LCB, 4: number of LCBs/requesters; must be >= 2.
- WAKE_LAT, 2: cycles an LCB is enabled before its group is declared ready; must be >= 1.
- HOLD_CYC, 8: cycles the enable persists after the request drops; must be >= 1.
- WAKE_GAP, 3: minimum cycles between successive wake grants; must be >= 1 (1 = back-to-back).

Ports:
- iccad_clk  input  1  sole clock; all state updates on rising edge.
- iccad_rst  input  1  reset; synchronous, active-high.
- req  input  NUM_LCB  per-group clock request, level-sensitive.
- lcb_en  output  NUM_LCB  per-LCB enable, registered.
- ready  output  NUM_LCB  group clock stable; registered.
- busy  output  1  any slot not OFF; registered.

Behaviour:
- Interface: one clock, iccad_clk. Reset iccad_rst is synchronous and active-high.
- Reset: every slot goes to OFF, gap counter to 0, round-robin pointer to 0. lcb_en, ready and busy are all 0 in the cycle after an edge with iccad_rst=1. Reset mid-operation aborts any WAKE or HOLD immediately, with no drain.
- Per-slot FSM, states OFF, WAIT, WAKE, ON, HOLD:
  - OFF -> WAIT when req[i]=1.
  - WAIT -> OFF when req[i]=0, taking priority over a grant in the same cycle. WAIT -> WAKE when granted.
  - WAKE lasts exactly WAKE_LAT cycles, then goes to ON if req[i]=1, else to HOLD. A req drop during WAKE is ignored until the end of WAKE.
  - ON -> HOLD when req[i]=0; the hold counter loads HOLD_CYC.
  - HOLD -> ON when req[i]=1, with no new wake and no arbitration. HOLD -> OFF after HOLD_CYC cycles with req[i]=0.
- Output decode:
  - lcb_en[i] = state in {WAKE, ON, HOLD}.
  - ready[i] = state in {ON, HOLD}.
  - busy = OR of slots not in OFF.
  - All three are driven from registered state, not combinationally from req.
- Arbitration:
  - At most one grant per cycle.
  - A grant is allowed only when the gap counter is 0 and at least one slot is in WAIT.
  - Winner: the first WAIT slot searching from the pointer upward, wrapping at NUM_LCB-1 -> 0.
  - On a grant to slot i: the pointer becomes (i+1) mod NUM_LCB and the gap counter loads WAKE_GAP-1.
  - The gap counter decrements each cycle while nonzero. The pointer is unchanged when there is no grant.
- Latency with a quiet arbiter: req high in cycle 0 -> WAIT in cycle 1 -> grant -> lcb_en=1 from cycle 2 -> ready=1 from cycle 2+WAKE_LAT.
- Counter widths: $clog2(max value + 1). No wrap is possible; counters saturate by construction.

Decomposition:
- Package lcb_wake_sched_pkg holds:
  - the slot state enum (OFF, WAIT, WAKE, ON, HOLD);
  - a width helper function for counter widths.
- Sub-module lcb_slot_fsm, instantiated NUM_LCB times. It owns one slot's state, wake counter and hold counter.
  - Inputs: req, grant.
  - Outputs: is_wait, lcb_en, ready, active.
- The top level holds the round-robin arbiter, the gap counter and busy.

Test Plan (defaults):
1. Single wake: req=4'b0001 from cycle 0 -> lcb_en[0]=1 from cycle 2; ready[0]=1 from cycle 4; busy=1 from cycle 1.
2. All request together: req=4'b1111 at cycle 0 -> lcb_en[0..3] rise in cycles 2, 5, 8, 11; ready rises in cycles 4, 7, 10, 13; never two grants within 3 cycles.
3. Hold and revive:
   - slot 0 in ON, req[0] dropped in cycle 10 -> HOLD from cycle 11; lcb_en[0] stays 1 through cycle 18 and is 0 in cycle 19.
   - Repeat with req[0]=1 again in cycle 15 -> ON in cycle 16 with no lcb_en glitch and no gap-counter load.
4. Withdrawn request: req[1] pulses for 1 cycle while the gap counter is nonzero -> slot 1 returns to OFF; lcb_en[1] never asserts; pointer unchanged.
5. Reset mid-wake: iccad_rst=1 in cycle 3 of scenario 1 -> lcb_en, ready, busy all 0 in cycle 4. After release with req still 1, the wake restarts with lcb_en from 2 cycles after release.
6. Round-robin: after a grant to slot 3, with slots 0 and 3 both in WAIT -> next grant goes to slot 0, then slot 3, three cycles apart.

Source files
------------

// File: rtl/lcb_wake_sched_pkg.sv
// lcb_wake_sched_pkg: shared slot state encoding and counter width helper
package lcb_wake_sched_pkg;
   typedef enum logic [2:0] {S_OFF, S_WAIT, S_WAKE, S_ON, S_HOLD} slot_state_e;
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/lcb_wake_sched_if.sv
// lcb_wake_sched_if: request/enable bundle between group activity logic and the LCB scheduler
//   req    activity logic -> scheduler, per-group clock request (level)
//   lcb_en scheduler -> LCB enable pins
//   ready  scheduler -> groups, group clock stable
//   busy   scheduler -> power control, any slot not OFF
interface lcb_wake_sched_if #(parameter int NUM_LCB = 4);
   logic [NUM_LCB-1:0] req;
   logic [NUM_LCB-1:0] lcb_en;
   logic [NUM_LCB-1:0] ready;
   logic               busy;
   modport master (output req, input lcb_en, ready, busy);
   modport slave  (input req, output lcb_en, ready, busy);
endinterface

// File: rtl/lcb_slot_fsm.sv
// lcb_slot_fsm: one LCB slot sequencing OFF/WAIT/WAKE/ON/HOLD
//   iccad_clk, iccad_rst  clock, synchronous active-high reset
//   i_req     group clock request
//   i_grant   wake grant from the arbiter
//   o_is_wait slot is waiting for a grant
//   o_lcb_en  LCB enable (WAKE, ON, HOLD)
//   o_ready   group clock stable (ON, HOLD)
//   o_active  slot not OFF
module lcb_slot_fsm
   import lcb_wake_sched_pkg::*;
#(
   parameter int WAKE_LAT = 2,
   parameter int HOLD_CYC = 8
) (
   input  logic iccad_clk,
   input  logic iccad_rst,
   input  logic i_req,
   input  logic i_grant,
   output logic o_is_wait,
   output logic o_lcb_en,
   output logic o_ready,
   output logic o_active
);
   localparam int WW = cnt_w(WAKE_LAT - 1);
   localparam int HW = cnt_w(HOLD_CYC);
   slot_state_e   r_state, w_state_nx;
   logic [WW-1:0] r_wcnt, w_wcnt_nx;
   logic [HW-1:0] r_hcnt, w_hcnt_nx;
   always_ff @(posedge iccad_clk) begin
      if (iccad_rst) begin
         r_state <= S_OFF;
         r_wcnt  <= '0;
         r_hcnt  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_wcnt  <= w_wcnt_nx;
         r_hcnt  <= w_hcnt_nx;
      end
   end
   // Wake counter loads WAKE_LAT-1 so WAKE spans exactly WAKE_LAT cycles;
   // hold counter loads HOLD_CYC and expires when it reaches 1.
   always_comb begin
      w_state_nx = r_state;
      w_wcnt_nx  = r_wcnt;
      w_hcnt_nx  = r_hcnt;
      case (r_state)
         S_OFF: w_state_nx = i_req ? S_WAIT : S_OFF;
         S_WAIT: begin
            if (!i_req) w_state_nx = S_OFF;
            else if (i_grant) begin
               w_state_nx = S_WAKE;
               w_wcnt_nx  = WW'(WAKE_LAT - 1);
            end
         end
         S_WAKE: begin
            if (r_wcnt != '0) w_wcnt_nx = r_wcnt - 1'b1;
            else if (i_req) w_state_nx = S_ON;
            else begin
               w_state_nx = S_HOLD;
               w_hcnt_nx  = HW'(HOLD_CYC);
            end
         end
         S_ON: begin
            if (!i_req) begin
               w_state_nx = S_HOLD;
               w_hcnt_nx  = HW'(HOLD_CYC);
            end
         end
         S_HOLD: begin
            if (i_req) w_state_nx = S_ON;
            else if (r_hcnt <= HW'(1)) w_state_nx = S_OFF;
            else w_hcnt_nx = r_hcnt - 1'b1;
         end
         default: w_state_nx = S_OFF;
      endcase
   end
   assign o_is_wait = (r_state == S_WAIT);
   assign o_lcb_en  = (r_state == S_WAKE) || (r_state == S_ON) || (r_state == S_HOLD);
   assign o_ready   = (r_state == S_ON) || (r_state == S_HOLD);
   assign o_active  = (r_state != S_OFF);
endmodule

// File: rtl/lcb_wake_sched.sv
// lcb_wake_sched: LCB clock-enable scheduler with spaced round-robin wake grants
//   iccad_clk, iccad_rst  clock, synchronous active-high reset
//   bus.req     per-group clock request
//   bus.lcb_en  per-LCB enable
//   bus.ready   per-group clock stable
//   bus.busy    any slot not OFF
module lcb_wake_sched
   import lcb_wake_sched_pkg::*;
#(
   parameter int NUM_LCB  = 4,
   parameter int WAKE_LAT = 2,
   parameter int HOLD_CYC = 8,
   parameter int WAKE_GAP = 3
) (
   input  logic iccad_clk,
   input  logic iccad_rst,
   lcb_wake_sched_if.slave bus
);
   localparam int PW = $clog2(NUM_LCB);
   localparam int GW = cnt_w(WAKE_GAP - 1);
   logic [PW-1:0]      r_ptr, w_win, w_idx, w_ptr_nx;
   logic [GW-1:0]      r_gap;
   logic [NUM_LCB-1:0] w_wait, w_grant, w_active;
   logic               w_any;
   // First WAIT slot at or above the pointer, wrapping; one grant only when the gap has elapsed.
   always_comb begin
      w_any   = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      w_grant = '0;
      for (int k = 0; k < NUM_LCB; k++) begin
         w_idx = PW'((int'(r_ptr) + k) % NUM_LCB);
         if (!w_any && w_wait[w_idx]) begin
            w_any = 1'b1;
            w_win = w_idx;
         end
      end
      if (w_any && r_gap == '0) w_grant[w_win] = 1'b1;
      w_ptr_nx = (w_win == PW'(NUM_LCB - 1)) ? '0 : w_win + 1'b1;
   end
   always_ff @(posedge iccad_clk) begin
      if (iccad_rst) begin
         r_ptr <= '0;
         r_gap <= '0;
      end else if (w_grant != '0) begin
         r_ptr <= w_ptr_nx;
         r_gap <= GW'(WAKE_GAP - 1);
      end else if (r_gap != '0) begin
         r_gap <= r_gap - 1'b1;
      end
   end
   for (genvar i = 0; i < NUM_LCB; i++) begin : g_slot
      lcb_slot_fsm #(.WAKE_LAT(WAKE_LAT), .HOLD_CYC(HOLD_CYC)) u_slot (
         .iccad_clk (iccad_clk),
         .iccad_rst (iccad_rst),
         .i_req     (bus.req[i]),
         .i_grant   (w_grant[i]),
         .o_is_wait (w_wait[i]),
         .o_lcb_en  (bus.lcb_en[i]),
         .o_ready   (bus.ready[i]),
         .o_active  (w_active[i])
      );
   end
   assign bus.busy = |w_active;
endmodule

// File: tb/tb_lcb_wake_sched.sv
// tb_lcb_wake_sched: directed self-checking bench for lcb_wake_sched with default parameters
module tb_lcb_wake_sched;
   logic iccad_clk = 1'b0;
   logic iccad_rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [3:0] e_en, e_rdy;
   logic       e_busy;

   lcb_wake_sched_if #(.NUM_LCB(4)) bus ();

   lcb_wake_sched #(.NUM_LCB(4), .WAKE_LAT(2), .HOLD_CYC(8), .WAKE_GAP(3)) dut (
      .iccad_clk (iccad_clk),
      .iccad_rst (iccad_rst),
      .bus       (bus)
   );

   always #5 iccad_clk = ~iccad_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge iccad_clk);
   endtask

   task automatic do_reset();
      iccad_rst = 1'b1;
      bus.req   = '0;
      cyc();
      cyc();
      chk("rst lcb_en", 32'(bus.lcb_en), 0);
      chk("rst ready", 32'(bus.ready), 0);
      chk("rst busy", 32'(bus.busy), 0);
      iccad_rst = 1'b0;
   endtask

   task automatic chk_all(input string t, input int c);
      chk($sformatf("%s en c%0d", t, c), 32'(bus.lcb_en), 32'(e_en));
      chk($sformatf("%s rdy c%0d", t, c), 32'(bus.ready), 32'(e_rdy));
      chk($sformatf("%s busy c%0d", t, c), 32'(bus.busy), 32'(e_busy));
   endtask

   initial begin
      bus.req = '0;
      // single wake, then ON -> HOLD -> OFF
      do_reset();
      bus.req = 4'b0001;
      for (int c = 1; c <= 20; c++) begin
         cyc();
         e_en = '0; e_rdy = '0;
         if (c <= 10) begin
            e_en[0] = (c >= 2); e_rdy[0] = (c >= 4); e_busy = 1'b1;
         end else begin
            e_en[0] = (c <= 18); e_rdy[0] = (c <= 18); e_busy = (c <= 18);
         end
         chk_all("single", c);
         if (c == 10) bus.req = 4'b0000;
      end
      // hold then revive; slot 1 asks at the same time and must not see a gap
      do_reset();
      bus.req = 4'b0001;
      for (int c = 1; c <= 22; c++) begin
         cyc();
         e_en = '0; e_rdy = '0; e_busy = 1'b1;
         e_en[0] = (c >= 2); e_rdy[0] = (c >= 4);
         e_en[1] = (c >= 17); e_rdy[1] = (c >= 19);
         chk_all("revive", c);
         if (c == 10) bus.req = 4'b0000;
         if (c == 15) bus.req = 4'b0011;
      end
      // all request together: wakes spaced three cycles apart
      do_reset();
      bus.req = 4'b1111;
      for (int c = 1; c <= 14; c++) begin
         cyc();
         e_busy = 1'b1;
         for (int s = 0; s < 4; s++) begin
            e_en[s]  = (c >= 2 + 3 * s);
            e_rdy[s] = (c >= 4 + 3 * s);
         end
         chk_all("all", c);
      end
      // withdrawn request while gap counter runs; pointer must stay at 1
      do_reset();
      bus.req = 4'b0001;
      for (int c = 1; c <= 11; c++) begin
         cyc();
         e_en = '0;
         e_en[0] = (c >= 2); e_en[1] = (c >= 7); e_en[2] = (c >= 10);
         chk($sformatf("withdraw en c%0d", c), 32'(bus.lcb_en), 32'(e_en));
         chk($sformatf("withdraw busy c%0d", c), 32'(bus.busy), 1);
         if (c == 1) bus.req = 4'b0011;
         if (c == 2) bus.req = 4'b0001;
         if (c == 5) bus.req = 4'b0111;
      end
      // reset mid-wake, then restart
      do_reset();
      bus.req = 4'b0001;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         e_en = '0; e_rdy = '0;
         if (c <= 3) begin
            e_en[0] = (c >= 2); e_busy = 1'b1;
         end else if (c == 4) begin
            e_busy = 1'b0;
         end else begin
            e_en[0] = (c >= 6); e_rdy[0] = (c >= 8); e_busy = 1'b1;
         end
         chk_all("rstwake", c);
         if (c == 3) iccad_rst = 1'b1;
         if (c == 4) iccad_rst = 1'b0;
      end
      // round-robin: grant 1 then 3 leaves pointer at 0; slot 3 wakes into HOLD and expires
      do_reset();
      bus.req = 4'b1010;
      for (int c = 1; c <= 21; c++) begin
         cyc();
         e_en = '0;
         e_en[1] = (c >= 2);
         e_en[3] = (c >= 5 && c <= 14) || (c >= 20);
         e_en[0] = (c >= 17);
         chk($sformatf("rr en c%0d", c), 32'(bus.lcb_en), 32'(e_en));
         if (c == 5) bus.req = 4'b0010;
         if (c == 15) bus.req = 4'b1011;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
